// File: rtl/jam_pkg.sv
// Shared constants for the exhaustive job-assignment engine:
// FSM encoding, width helper and worker-count legality check.
package jam_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    // Ceiling log2, never below 1 so index ports keep a real bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit n_legal(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation,
// flagging the final (strictly descending) ordering.
module jam_next_perm #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N*IDX_W-1:0] perm_i,
    output logic [N*IDX_W-1:0] next_o,
    output logic               is_last_o
);

    logic [IDX_W-1:0] p [N];
    logic [IDX_W-1:0] q [N];
    logic [IDX_W-1:0] r [N];
    logic [IDX_W-1:0] pv;
    logic [IDX_W-1:0] sv;
    logic             found;
    int               piv;
    int               succ;

    always_comb begin
        found = 1'b0;
        piv   = 0;
        pv    = '0;
        sv    = '0;
        next_o = '0;
        for (int a = 0; a < N; a++) p[a] = perm_i[a*IDX_W +: IDX_W];
        for (int a = 0; a < N - 1; a++) begin
            if (p[a] < p[a+1]) begin
                found = 1'b1;
                piv   = a;
            end
        end
        for (int a = 0; a < N; a++) if (a == piv) pv = p[a];
        // Suffix is descending, so the rightmost larger entry is the smallest.
        succ = piv + 1;
        for (int a = 0; a < N; a++) begin
            if (a > piv && p[a] > pv) succ = a;
        end
        for (int a = 0; a < N; a++) if (a == succ) sv = p[a];
        for (int a = 0; a < N; a++) begin
            if (a == piv)       q[a] = sv;
            else if (a == succ) q[a] = pv;
            else                q[a] = p[a];
        end
        for (int a = 0; a < N; a++) begin
            r[a] = q[a];
            for (int c = 0; c < N; c++) begin
                if (a > piv && c == N + piv - a) r[a] = q[c];
            end
        end
        for (int a = 0; a < N; a++) next_o[a*IDX_W +: IDX_W] = r[a];
        is_last_o = ~found;
    end

endmodule

// File: rtl/jam_assign_n.sv
// Exhaustive N-worker / N-job assignment search over all N! orderings,
// tracking best total cost and its multiplicity in min or max mode.
module jam_assign_n
    import jam_pkg::*;
#(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int IDX_W  = clog2(N),
    parameter int SUM_W  = COST_W + clog2(N),
    parameter int MC_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Mode,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic [SUM_W-1:0]  BestCost,
    output logic [MC_W-1:0]   MatchCount,
    output logic              Busy,
    output logic              Done
);

    localparam int K_W = clog2(N + 1);

    if (!n_legal(N)) begin : g_bad_n
        $error("jam_assign_n: N must lie in 2..8");
    end

    logic [1:0]         state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   best_q, best_d;
    logic [MC_W-1:0]    mc_q, mc_d;
    logic               mode_q, mode_d;
    logic               first_q, first_d;
    logic [IDX_W-1:0]   perm_q [N];
    logic [IDX_W-1:0]   perm_d [N];
    logic [N*IDX_W-1:0] perm_flat;
    logic [N*IDX_W-1:0] next_flat;
    logic               is_last;
    logic               accept;
    logic               better;
    logic               fetching;

    always_comb begin
        perm_flat = '0;
        for (int i = 0; i < N; i++) perm_flat[i*IDX_W +: IDX_W] = perm_q[i];
    end

    jam_next_perm #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_next (
        .perm_i    (perm_flat),
        .next_o    (next_flat),
        .is_last_o (is_last)
    );

    assign accept = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign better = mode_q ? (acc_q > best_q) : (acc_q < best_q);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        best_d  = best_q;
        mc_d    = mc_q;
        mode_d  = mode_q;
        first_d = first_q;
        perm_d  = perm_q;
        if (accept) begin
            state_d = S_FETCH;
            k_d     = '0;
            acc_d   = '0;
            best_d  = '0;
            mc_d    = '0;
            mode_d  = Mode;
            first_d = 1'b1;
            for (int i = 0; i < N; i++) perm_d[i] = IDX_W'(i);
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // Cost lags W by one cycle, so slot k adds index k-1.
                    if (k_q != '0) acc_d = acc_q + SUM_W'(Cost);
                    if (k_q == K_W'(N)) state_d = S_EVAL;
                    else                k_d = k_q + 1'b1;
                end
                S_EVAL: begin
                    if (first_q || better) begin
                        best_d  = acc_q;
                        mc_d    = MC_W'(1);
                        first_d = 1'b0;
                    end else if (acc_q == best_q && mc_q != '1) begin
                        mc_d = mc_q + 1'b1;
                    end
                    k_d   = '0;
                    acc_d = '0;
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        for (int i = 0; i < N; i++)
                            perm_d[i] = next_flat[i*IDX_W +: IDX_W];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            mc_q    <= '0;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            for (int i = 0; i < N; i++) perm_q[i] <= IDX_W'(i);
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            mc_q    <= mc_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            perm_q  <= perm_d;
        end
    end

    assign fetching   = (state_q == S_FETCH) && (k_q < K_W'(N));
    assign W          = fetching ? k_q[IDX_W-1:0] : '0;
    assign J          = perm_q[W];
    assign BestCost   = best_q;
    assign MatchCount = mc_q;
    assign Busy       = (state_q == S_FETCH) || (state_q == S_EVAL);
    assign Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_jam_assign_n.sv
// Bench for jam_assign_n: four instances (N=2..5) driven by random and
// hand-built cost tables, checked cycle by cycle against a permutation model.
module tb_jam_assign_n;
    import jam_pkg::*;

    localparam int NS   [4]    = '{2, 3, 4, 5};
    localparam int KIND [4][2] = '{'{2, 0}, '{0, 0}, '{1, 1}, '{1, 0}};
    localparam int CVAL [4][2] = '{'{0, 0}, '{0, 0}, '{5, 127}, '{127, 0}};
    localparam int MODE [4][2] = '{'{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}};
    localparam int EXB  [4][2] = '{'{0, 20}, '{3, 30}, '{20, 508}, '{635, 50}};
    localparam int EXM  [4][2] = '{'{1, 1}, '{1, 2}, '{24, 24}, '{120, 44}};
    localparam int EXT  [4]    = '{9, 31, 145, 841};

    logic clk = 1'b0;
    int   vecs = 0;
    int   miscmp = 0;

    always #5 clk = ~clk;

    task automatic chk(input int n, input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL n%0d %s: got %0d expected %0d", n, nm, act, exp);
        end
    endtask

    function automatic int fact(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    // Element at position pos of the m-th permutation in lexicographic order.
    function automatic int perm_at(input int n, input int m, input int pos);
        bit used [8];
        int rem, f, d, cnt, v;
        for (int i = 0; i < 8; i++) used[i] = 1'b0;
        rem = m;
        v = 0;
        for (int i = 0; i <= pos; i++) begin
            f = fact(n - 1 - i);
            d = rem / f;
            rem = rem % f;
            cnt = 0;
            for (int c = 0; c < n; c++) begin
                if (!used[c]) begin
                    if (cnt == d) v = c;
                    cnt++;
                end
            end
            used[v] = 1'b1;
        end
        return v;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_run
        localparam int NN = NS[gi];
        localparam int IW = clog2(NN);
        localparam int SW = 7 + clog2(NN);

        logic          rst;
        logic          start;
        logic          mode;
        logic [IW-1:0] w;
        logic [IW-1:0] j;
        logic [6:0]    cost;
        logic [SW-1:0] best;
        logic [15:0]   mc;
        logic          busy;
        logic          done;
        bit            fin = 1'b0;
        int            tab [NN][NN];

        jam_assign_n #(
            .N      (NN),
            .COST_W (7),
            .IDX_W  (IW),
            .SUM_W  (SW),
            .MC_W   (16)
        ) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .Start      (start),
            .Mode       (mode),
            .W          (w),
            .J          (j),
            .Cost       (cost),
            .BestCost   (best),
            .MatchCount (mc),
            .Busy       (busy),
            .Done       (done)
        );

        // External cost table with one cycle of read latency.
        always @(posedge clk) cost <= 7'(tab[w][j]);

        task automatic build_tab(input int kind, input int val);
            for (int a = 0; a < NN; a++)
                for (int b = 0; b < NN; b++)
                    case (kind)
                        0:       tab[a][b] = (a == b) ? 1 : 10;
                        1:       tab[a][b] = val;
                        2:       tab[a][b] = (a + b == NN - 1) ? 0 : 7;
                        default: tab[a][b] = $urandom_range(0, val);
                    endcase
        endtask

        task automatic model(input bit md, output int b, output int c);
            int sums [$];
            int s;
            sums = {};
            for (int m = 0; m < fact(NN); m++) begin
                s = 0;
                for (int a = 0; a < NN; a++) s += tab[a][perm_at(NN, m, a)];
                sums.push_back(s);
            end
            b = sums[0];
            foreach (sums[i]) if (md ? sums[i] > b : sums[i] < b) b = sums[i];
            c = 0;
            foreach (sums[i]) if (sums[i] == b) c++;
        endtask

        task automatic chk_reset();
            chk(NN, "rst_w", w, 0);
            chk(NN, "rst_j", j, 0);
            chk(NN, "rst_best", best, 0);
            chk(NN, "rst_mc", mc, 0);
            chk(NN, "rst_busy", busy, 0);
            chk(NN, "rst_done", done, 0);
        endtask

        task automatic do_run(input bit md, input int pulse_at, input int rst_at,
                              output int tdone);
            int eb, ec, tt, s, m, ew, ej;
            model(md, eb, ec);
            tt = fact(NN) * (NN + 2) + 1;
            tdone = -1;
            @(negedge clk);
            start = 1'b1;
            mode  = md;
            @(negedge clk);
            start = 1'b0;
            for (int t = 1; t <= tt + 2; t++) begin
                if (t == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk_reset();
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                chk(NN, "busy", busy, int'(t < tt));
                chk(NN, "done", done, int'(t >= tt));
                if (t < tt) begin
                    s  = (t - 1) % (NN + 2);
                    m  = (t - 1) / (NN + 2);
                    ew = (s < NN) ? s : 0;
                    ej = perm_at(NN, m, ew);
                end else begin
                    ew = 0;
                    ej = NN - 1;
                end
                chk(NN, "w", w, ew);
                chk(NN, "j", j, ej);
                if (t >= tt) begin
                    chk(NN, "best", best, eb);
                    chk(NN, "mcount", mc, ec);
                end
                if (done && tdone < 0) tdone = t;
                start = (t == pulse_at);
                mode  = (t == pulse_at) ? ~md : md;
                @(negedge clk);
            end
            start = 1'b0;
            chk(NN, "t_done", tdone, tt);
        endtask

        initial begin
            int td, eb, ec;
            rst   = 1'b1;
            start = 1'b0;
            mode  = 1'b0;
            build_tab(1, 0);
            repeat (3) @(negedge clk);
            chk_reset();
            rst = 1'b0;
            @(negedge clk);
            chk_reset();
            for (int r = 0; r < 2; r++) begin
                build_tab(KIND[gi][r], CVAL[gi][r]);
                model(MODE[gi][r] != 0, eb, ec);
                chk(NN, "model_best", eb, EXB[gi][r]);
                chk(NN, "model_cnt", ec, EXM[gi][r]);
                do_run(MODE[gi][r] != 0, (r == 1) ? NN + 3 : 0, 0, td);
                chk(NN, "cycles", td, EXT[gi]);
                chk(NN, "best_lit", best, EXB[gi][r]);
                chk(NN, "cnt_lit", mc, EXM[gi][r]);
            end
            do_run(MODE[gi][1] != 0, 0, 0, td);
            chk(NN, "rerun_best", best, EXB[gi][1]);
            build_tab(3, 127);
            do_run(1'b0, 0, fact(NN) * (NN + 2) / 2, td);
            do_run(1'b0, 0, 0, td);
            for (int r = 0; r < 4; r++) begin
                build_tab(3, r[0] ? 127 : 3);
                do_run(r[1], 0, 0, td);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(g_run[0].fin && g_run[1].fin && g_run[2].fin && g_run[3].fin)
               && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        if (!(g_run[0].fin && g_run[1].fin && g_run[2].fin && g_run[3].fin)) begin
            miscmp++;
            $display("FAIL timeout: got %0d cycles, required completion", guard);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/jam_assign_n.md
# jam_assign_n

Parametrised exhaustive job-assignment engine. For N workers and N jobs it walks all N! assignments in lexicographic order and reads each worker/job cost from an external cost table through the W/J/Cost lookup port. It reports the best total cost and how many assignments reach it, in min or max mode. It is the configurable, restartable successor to the fixed 8×8 JAM engine and sits in the same solver subsystem, with an explicit Start/Busy/Done handshake.

## Interface
- N, 8: worker/job count, legal 2..8.
- COST_W, 7: width of one Cost entry.
- IDX_W, clog2(N) (min 1): width of W and J.
- SUM_W, COST_W+clog2(N): accumulator and BestCost width; it cannot overflow.
- MC_W, 16: MatchCount width. 16 covers 8! = 40320.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request. Accepted only when Busy=0.
- Mode  in  1  0 = minimise, 1 = maximise. Sampled on the accepted Start.
- W  out  IDX_W  worker index presented to the cost table.
- J  out  IDX_W  job index presented to the cost table; always perm[W].
- Cost  in  COST_W  cost of (W, J) from the previous cycle. Fixed 1-cycle table latency.
- BestCost  out  SUM_W  best total found.
- MatchCount  out  MC_W  number of assignments equal to BestCost.
- Busy  out  1  high from the cycle after an accepted Start until Done rises.
- Done  out  1  level. High from end of search until the next accepted Start.

## Operation
- Reset: W=0, J=0, BestCost=0, MatchCount=0, Busy=0, Done=0, perm = identity (0..N-1), FSM in IDLE.
- FSM states: IDLE, FETCH, EVAL, DONE.
- IDLE or DONE, Start=1 → FETCH.
  - Clear Done, BestCost and MatchCount; set perm = identity; latch Mode; set first_flag=1.
- FETCH lasts N+1 cycles, with fetch counter k = 0..N.
  - For k<N: W=k, J=perm[k].
  - For k≥1: acc += Cost, so the cost for index k-1 is captured at cycle k.
  - acc is cleared on FETCH entry.
- EVAL lasts 1 cycle.
  - If first_flag: BestCost=acc, MatchCount=1, clear first_flag.
  - Else if acc is better (strictly less in mode 0, strictly greater in mode 1): BestCost=acc, MatchCount=1.
  - Else if acc==BestCost: MatchCount+1, saturating at all-ones.
  - Then, if perm is the last permutation (strictly descending) → DONE; else perm = next_perm(perm) → FETCH.
- next_perm is the standard algorithm: find the rightmost i with perm[i]<perm[i+1]; swap perm[i] with the smallest greater element to its right; reverse the suffix after i.
- DONE: Done=1, Busy=0; results held stable until the next accepted Start.
- Outside FETCH: W=0, J=perm[0].
- Start while Busy is ignored. No restart and no state change.

## Timing
- Each permutation takes N+2 cycles (N+1 FETCH, 1 EVAL).
- Total from the accepted Start edge to Done high: N!·(N+2)+1 cycles.
  - N=3: 31.
  - N=8: 403201.
- Busy rises on the cycle after Start and falls in the same cycle Done rises.
- BestCost and MatchCount update only on the EVAL edge. Intermediate values are visible while Busy but are valid only while Done=1.
- RST asserted mid-search: all state returns to reset values asynchronously, and nothing is retained.
- Start and RST asserted together: RST wins.

## Structure
- Package jam_pkg holds:
  - the FSM state encoding (IDLE/FETCH/EVAL/DONE);
  - the clog2 constant function;
  - N legality checks (elaboration error if N<2 or N>8).
- Sub-module jam_next_perm: combinational, parametrised by N and IDX_W.
  - Input: the flattened perm vector.
  - Outputs: the next perm vector and an is_last flag.
- The top holds the FSM, fetch counter, accumulator, compare/update and handshake logic.

## Test plan
- N=3, Mode=0, Cost(w,j) = 1 if w==j else 10 → BestCost=3, MatchCount=1, Done exactly 31 cycles after Start.
- N=3, Mode=1, same table → BestCost=30, MatchCount=2 (the two derangements).
- N=4, all Cost=5, Mode=0 → BestCost=20, MatchCount=24. Check W/J stepping 0..3 with J=perm[W], and the 1-cycle Cost lag.
- N=8, COST_W=7, all Cost=127 → BestCost=1016, MatchCount=40320, no overflow. Also the IC-contest JAM table with known golden MinCost/MatchCount.
- Start pulsed mid-search is ignored; RST mid-search then Start gives the same result as a clean run; second Start after Done clears Done and reproduces the results.
- N=2, Cost(0,1)=Cost(1,0)=0, others 7, Mode=0 → BestCost=0, MatchCount=1, Done 9 cycles after Start.
